// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative RV64M multiply/divide execute unit.
//
// Takes one multiply/divide operation at a time over a valid/ready
// handshake. Multiplies finish in a fixed two cycles. Divides and
// remainders use a radix-2 restoring loop that produces one quotient bit
// per cycle, followed by one sign-fixup cycle. Divide-by-zero and signed
// overflow are resolved when the operation is accepted, so they skip the
// loop.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit idle and able to accept
//   in_op      mult_t opcode: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5
//              REM=6 REMU=7 MULW=8; codes 9..15 execute as MUL
//   in_a       rs1 operand
//   in_b       rs2 operand
//   flush      kill any in-flight or completed operation (pipeline redirect)
//   out_valid  result available
//   out_ready  consumer takes the result
//   out_result result value; holds its last value until the next one is written
module multdiv_unit #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DIV_ITERS = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned CntW = $clog2(DIV_ITERS);

    localparam logic [3:0] OpMulh   = 4'd1;
    localparam logic [3:0] OpMulhsu = 4'd2;
    localparam logic [3:0] OpMulhu  = 4'd3;
    localparam logic [3:0] OpDiv    = 4'd4;
    localparam logic [3:0] OpRem    = 4'd6;
    localparam logic [3:0] OpMulw   = 4'd8;

    localparam logic [XLEN-1:0] XlenMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              quot_neg_q, quot_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Accept-time decode of the incoming request.
    logic            in_div_fam;
    logic            in_signed_div;
    logic            in_a_neg;
    logic            in_b_neg;
    logic [XLEN-1:0] in_abs_a;
    logic [XLEN-1:0] in_abs_b;
    logic            in_b_zero;
    logic            in_ovf;

    always_comb begin
        in_div_fam    = (in_op[3:2] == 2'b01);
        in_signed_div = (in_op == OpDiv) || (in_op == OpRem);
        in_a_neg      = in_signed_div & in_a[XLEN-1];
        in_b_neg      = in_signed_div & in_b[XLEN-1];
        in_abs_a      = in_a_neg ? (~in_a + 1'b1) : in_a;
        in_abs_b      = in_b_neg ? (~in_b + 1'b1) : in_b;
        in_b_zero     = (in_b == '0);
        in_ovf        = in_signed_div && (in_a == XlenMin) && (in_b == '1);
    end

    // Multiply datapath. Operands are sign- or zero-extended to 2*XLEN so
    // the low 2*XLEN bits of the product are exact for every signedness mix.
    logic              mul_a_signed;
    logic              mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] mul_prod;
    logic [31:0]       mulw_lo;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_a_signed = (op_q == OpMulh) || (op_q == OpMulhsu);
        mul_b_signed = (op_q == OpMulh);
        mul_a_ext    = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
        mul_b_ext    = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
        mul_prod     = mul_a_ext * mul_b_ext;
        mulw_lo      = a_q[31:0] * b_q[31:0];
        case (op_q)
            OpMulh, OpMulhsu, OpMulhu: mul_res = mul_prod[2*XLEN-1:XLEN];
            OpMulw:                    mul_res = {{(XLEN-32){mulw_lo[31]}}, mulw_lo};
            default:                   mul_res = mul_prod[XLEN-1:0];
        endcase
    end

    // Restoring divide step: the dividend sits in quot_q and is shifted out
    // MSB-first into the partial remainder while quotient bits shift in.
    // The partial remainder stays below the divisor, so an XLEN+1-bit
    // difference always has a valid sign bit.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic [XLEN-1:0] quot_fixed;
    logic [XLEN-1:0] rem_fixed;

    always_comb begin
        rem_shift  = {rem_q, quot_q[XLEN-1]};
        rem_diff   = rem_shift - {1'b0, divisor_q};
        quot_fixed = quot_neg_q ? (~quot_q + 1'b1) : quot_q;
        rem_fixed  = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;

        if (flush) begin
            // Redirect wins over everything, including a completing handshake.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d = in_op;
                        a_d  = in_a;
                        b_d  = in_b;
                        if (in_div_fam) begin
                            if (in_b_zero) begin
                                // in_op[1] distinguishes REM/REMU from DIV/DIVU.
                                result_d = in_op[1] ? in_a : '1;
                                state_d  = StDone;
                            end else if (in_ovf) begin
                                result_d = in_op[1] ? '0 : in_a;
                                state_d  = StDone;
                            end else begin
                                quot_d     = in_abs_a;
                                rem_d      = '0;
                                divisor_d  = in_abs_b;
                                cnt_d      = '0;
                                quot_neg_d = in_a_neg ^ in_b_neg;
                                rem_neg_d  = in_a_neg;
                                state_d    = StDiv;
                            end
                        end else begin
                            state_d = StMul;
                        end
                    end
                end
                StMul: begin
                    result_d = mul_res;
                    state_d  = StDone;
                end
                StDiv: begin
                    if (!rem_diff[XLEN]) begin
                        rem_d  = rem_diff[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d  = rem_shift[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DIV_ITERS - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = op_q[1] ? rem_fixed : quot_fixed;
                    state_d  = StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign out_result = result_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed and randomized self-checking bench for multdiv_unit.
// Expected results come from a plain-arithmetic RV64M reference model and a
// latency rule computed from the operation class.
module tb_multdiv_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [63:0] in_a = 64'd0;
    logic [63:0] in_b = 64'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    multdiv_unit #(.XLEN(64), .DIV_ITERS(64)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: RV64M semantics with wide arithmetic.
    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        logic [63:0]  w;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'd0, a};
        ub = {64'd0, b};
        case (op)
            4'd1: begin p = sa * sb; return p[127:64]; end
            4'd2: begin p = sa * ub; return p[127:64]; end
            4'd3: begin p = ua * ub; return p[127:64]; end
            4'd4: begin
                if (b == 64'd0) return ONES;
                if (a == MIN && b == ONES) return a;
                return $signed(a) / $signed(b);
            end
            4'd5: begin
                if (b == 64'd0) return ONES;
                return a / b;
            end
            4'd6: begin
                if (b == 64'd0) return a;
                if (a == MIN && b == ONES) return 64'd0;
                return $signed(a) % $signed(b);
            end
            4'd7: begin
                if (b == 64'd0) return a;
                return a % b;
            end
            4'd8: begin
                w = {32'd0, a[31:0]} * {32'd0, b[31:0]};
                return {{32{w[31]}}, w[31:0]};
            end
            default: begin p = ua * ub; return p[63:0]; end
        endcase
    endfunction

    // Cycle (accept edge = 0) at which out_valid first shows.
    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
        if (op >= 4'd4 && op <= 4'd7) begin
            if (b == 64'd0) return 1;
            if ((op == 4'd4 || op == 4'd6) && a == MIN && b == ONES) return 1;
            return 66;
        end
        return 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b);
        logic [63:0] exp;
        int          lat;
        int          cyc;
        exp = ref_model(op, a, b);
        lat = exp_lat(op, a, b);
        check({tag, "/ready"}, 64'(in_ready), 64'd1);
        issue(op, a, b);
        wait_valid(cyc);
        check({tag, "/valid"}, 64'(out_valid), 64'd1);
        check({tag, "/latency"}, 64'(cyc), 64'(lat));
        check({tag, "/result"}, out_result, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/idle_after"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] a, b, exp;
        int          cyc;
        bit          seen;

        // Reset state.
        #2;
        check("reset/in_ready", 64'(in_ready), 64'd1);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/out_result", out_result, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run_op("mul_7_m3", 4'd0, 64'd7, -64'sd3);
        run_op("mulhu_ones", 4'd3, ONES, ONES);
        run_op("mulh_neg", 4'd1, -64'sd5, 64'h0123_4567_89AB_CDEF);
        run_op("mulhsu", 4'd2, -64'sd1, ONES);
        run_op("mulw_wrap", 4'd8, 64'h0000_0001_8000_0000, 64'd2);
        run_op("mulw_sext", 4'd8, 64'h4000_0000, 64'd2);
        run_op("div_m7_2", 4'd4, -64'sd7, 64'd2);
        run_op("rem_m7_2", 4'd6, -64'sd7, 64'd2);
        run_op("divu_100_7", 4'd5, 64'd100, 64'd7);
        run_op("remu_100_7", 4'd7, 64'd100, 64'd7);
        run_op("div_by0", 4'd4, 64'd5, 64'd0);
        run_op("rem_by0", 4'd6, 64'd5, 64'd0);
        run_op("divu_by0", 4'd5, 64'd9, 64'd0);
        run_op("remu_by0", 4'd7, 64'd9, 64'd0);
        run_op("div_ovf", 4'd4, MIN, ONES);
        run_op("rem_ovf", 4'd6, MIN, ONES);
        run_op("divu_min_m1", 4'd5, MIN, ONES);
        run_op("op12_as_mul", 4'd12, 64'd123456, 64'd789);

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: b = ONES;
                2: b = 64'($urandom_range(1, 100));
                default: b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = MIN;
                b = ONES;
            end
            run_op($sformatf("rnd%0d", i), op, a, b);
        end

        // Flush at cycle 30 of a divide.
        issue(4'd4, 64'd1000, 64'd3);
        repeat (29) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_div/idle", {62'd0, in_ready, out_valid}, 64'd2);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_div/no_valid", 64'(seen), 64'd0);
        run_op("after_flush_mul", 4'd0, 64'hDEAD_BEEF, 64'h1234_5678);

        // Back-pressure: result stable and no accept while held in DONE.
        exp = ref_model(4'd5, 64'd1_000_003, 64'd17);
        issue(4'd5, 64'd1_000_003, 64'd17);
        wait_valid(cyc);
        check("bp/latency", 64'(cyc), 64'd66);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_a     = 64'd3;
        in_b     = 64'd3;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp/valid%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("bp/ready%0d", k), 64'(in_ready), 64'd0);
            check($sformatf("bp/result%0d", k), out_result, exp);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp/idle", {62'd0, in_ready, out_valid}, 64'd2);
        check("bp/hold_result", out_result, exp);

        // Flush in DONE together with out_ready: result is dropped.
        exp = ref_model(4'd0, 64'd11, 64'd13);
        issue(4'd0, 64'd11, 64'd13);
        wait_valid(cyc);
        check("flush_done/valid", 64'(out_valid), 64'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_done/idle", {62'd0, in_ready, out_valid}, 64'd2);
        check("flush_done/hold", out_result, exp);

        // Flush with in_valid while idle: nothing accepted.
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 4'd4;
        in_a     = 64'd77;
        in_b     = 64'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle/not_taken", {62'd0, in_ready, out_valid}, 64'd2);
        @(posedge clk);
        #1;
        check("flush_idle/still_idle", {62'd0, in_ready, out_valid}, 64'd2);

        // Asynchronous reset in the middle of a divide.
        issue(4'd6, -64'sd12345, 64'd97);
        repeat (10) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("areset/in_ready", 64'(in_ready), 64'd1);
        check("areset/out_valid", 64'(out_valid), 64'd0);
        check("areset/out_result", out_result, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("areset/no_valid", 64'(seen), 64'd0);
        run_op("after_reset_div", 4'd4, 64'd1_000_000, -64'sd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
